// File: rtl/interpreter_sequencer.sv
// rtl/interpreter_sequencer.sv - ESN readout sequencer: 2-entry state FIFO, interpreter launch, washout, timeout
// Buffers reservoir vectors, runs one interpreter evaluation per vector, drops washout results.
module interpreter_sequencer #(
    parameter int reservoir_size = 4,
    parameter int data_width     = 3,
    parameter int layer          = 1,
    parameter int weight_size    = 2,
    parameter int WASHOUT        = 8,
    parameter int TIMEOUT        = 64,
    localparam int SW = reservoir_size * data_width,
    localparam int OW = (data_width + weight_size + layer) * 2 + 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iStateVld,
    input  logic [SW-1:0] iState,
    output logic          oStateRdy,
    output logic          oIntEn,
    output logic [SW-1:0] oIntData,
    input  logic [OW-1:0] iIntValue,
    input  logic          iIntRdy,
    output logic          oResVld,
    output logic [OW-1:0] oResData,
    input  logic          iResRdy,
    output logic [15:0]   oSampleCnt,
    output logic          oTimeout,
    output logic          oBusy
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]   WASH16   = 16'(WASHOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   fifo_mem_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      cnt_q, cnt_d;
    logic            state_rdy_q;
    logic            push, pop;

    logic [SW-1:0]   int_data_q, int_data_d;
    logic            int_en_q;
    logic            res_vld_q, res_vld_d;
    logic [OW-1:0]   res_data_q, res_data_d;
    logic [15:0]     sample_cnt_q, sample_cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            timeout_q, timeout_d;
    logic            busy_q;

    // Ready is the registered inverse of full, so a push never lands in a full FIFO.
    assign push = iStateVld && state_rdy_q;
    assign pop  = (state_q == IDLE) && (cnt_q != 2'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= iState;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            state_rdy_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q       <= cnt_d;
            state_rdy_q <= (cnt_d != 2'd2);
        end
    end

    always_comb begin
        state_d      = state_q;
        int_data_d   = int_data_q;
        res_vld_d    = res_vld_q;
        res_data_d   = res_data_q;
        sample_cnt_d = sample_cnt_q;
        tmo_d        = tmo_q;
        timeout_d    = timeout_q;
        case (state_q)
            IDLE: begin
                if (cnt_q != 2'd0) begin
                    int_data_d = fifo_mem_q[rd_ptr_q];
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                tmo_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // A result on the final allowed cycle beats the timeout.
                if (iIntRdy) begin
                    if (sample_cnt_q != 16'hFFFF) begin
                        sample_cnt_d = sample_cnt_q + 16'd1;
                    end
                    if (sample_cnt_q < WASH16) begin
                        state_d = IDLE;
                    end else begin
                        res_data_d = iIntValue;
                        res_vld_d  = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HOLD: begin
                if (iResRdy) begin
                    res_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q      <= IDLE;
            int_data_q   <= '0;
            int_en_q     <= 1'b0;
            res_vld_q    <= 1'b0;
            res_data_q   <= '0;
            sample_cnt_q <= '0;
            tmo_q        <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_data_q   <= int_data_d;
            int_en_q     <= (state_d == RUN);
            res_vld_q    <= res_vld_d;
            res_data_q   <= res_data_d;
            sample_cnt_q <= sample_cnt_d;
            tmo_q        <= tmo_d;
            timeout_q    <= timeout_d;
            busy_q       <= (state_d != IDLE) || (cnt_d != 2'd0);
        end
    end

    assign oStateRdy  = state_rdy_q;
    assign oIntEn     = int_en_q;
    assign oIntData   = int_data_q;
    assign oResVld    = res_vld_q;
    assign oResData   = res_data_q;
    assign oSampleCnt = sample_cnt_q;
    assign oTimeout   = timeout_q;
    assign oBusy      = busy_q;

endmodule

// File: tb/tb_interpreter_sequencer.sv
// tb/tb_interpreter_sequencer.sv - randomized scoreboard bench for interpreter_sequencer
module tb_interpreter_sequencer;

    localparam int WASH = 8;
    localparam int TMO  = 64;
    localparam int SW   = 12;
    localparam int OW   = 13;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iStateVld = 1'b0;
    logic [SW-1:0] iState = '0;
    logic          oStateRdy;
    logic          oIntEn;
    logic [SW-1:0] oIntData;
    logic [OW-1:0] iIntValue = '0;
    logic          iIntRdy = 1'b0;
    logic          oResVld;
    logic [OW-1:0] oResData;
    logic          iResRdy = 1'b0;
    logic [15:0]   oSampleCnt;
    logic          oTimeout;
    logic          oBusy;

    interpreter_sequencer #(.WASHOUT(WASH), .TIMEOUT(TMO)) dut (
        .iClk(iClk), .iRst(iRst), .iStateVld(iStateVld), .iState(iState),
        .oStateRdy(oStateRdy), .oIntEn(oIntEn), .oIntData(oIntData),
        .iIntValue(iIntValue), .iIntRdy(iIntRdy), .oResVld(oResVld),
        .oResData(oResData), .iResRdy(iResRdy), .oSampleCnt(oSampleCnt),
        .oTimeout(oTimeout), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    // Reference model: every accepted vector is evaluated in order; the interpreter
    // answers after a chosen delay (or never). Results after the washout are expected downstream.
    logic [SW-1:0] interp_v_q [$];
    int            interp_d_q [$];
    logic [OW-1:0] exp_q [$];
    int            mcnt = 0;
    logic          exp_tmo = 1'b0;
    logic          bp = 1'b0;
    int            res_pulses = 0;
    int            tmo_len = 0;

    function automatic logic [OW-1:0] interp_fn(input logic [SW-1:0] v);
        return {v, 1'b1} ^ 13'h0A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [SW-1:0] v, input int d);
        interp_v_q.push_back(v);
        interp_d_q.push_back(d);
        if (d <= TMO - 1) begin
            if (mcnt >= WASH) exp_q.push_back(interp_fn(v));
            if (mcnt < 65535) mcnt++;
        end else begin
            exp_tmo = 1'b1;
        end
    endtask

    task automatic push(input logic [SW-1:0] v, input int d);
        int guard = 0;
        @(negedge iClk);
        iStateVld = 1'b1;
        iState    = v;
        while (!oStateRdy && guard < 1000) begin
            @(negedge iClk);
            guard++;
        end
        if (guard >= 1000) chk("push_timeout", 32'(oStateRdy), 32'd1);
        else model_accept(v, d);
        @(posedge iClk);
        #1 iStateVld = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge iClk);
        while ((oBusy || oResVld) && guard < 5000) begin
            @(negedge iClk);
            guard++;
        end
        if (guard >= 5000) chk("idle_timeout", 32'(oBusy), 32'd0);
    endtask

    // Interpreter model: answers each evaluation on its chosen RUN cycle.
    initial begin
        logic          prev = 1'b0;
        int            k = 0, cur_d = 0, low_len = 100, run_len = 0;
        logic [SW-1:0] cur_v;
        forever begin
            @(negedge iClk);
            if (iRst) begin
                prev = 1'b0; iIntRdy = 1'b0; low_len = 100; k = 0;
            end else begin
                if (oIntEn && !prev) begin
                    total++;
                    if (low_len < 2) begin
                        bad++;
                        $display("FAIL en_gap: got %0d low cycles expected >=2", low_len);
                    end
                    if (interp_v_q.size() == 0) begin
                        chk("unexpected_eval", 32'd1, 32'd0);
                        cur_v = '0; cur_d = 1000;
                    end else begin
                        cur_v = interp_v_q.pop_front();
                        cur_d = interp_d_q.pop_front();
                        chk("int_data", 32'(oIntData), 32'(cur_v));
                    end
                    k = 0;
                end
                if (oIntEn) begin
                    iIntRdy   = (k == cur_d);
                    iIntValue = (k == cur_d) ? interp_fn(oIntData) : OW'($urandom);
                    k++;
                    run_len = k;
                    low_len = 0;
                end else begin
                    if (prev && cur_d >= TMO) tmo_len = run_len;
                    iIntRdy = 1'b0;
                    low_len++;
                end
                prev = oIntEn;
            end
        end
    end

    // Result monitor: pops the scoreboard on each new result and checks it holds until taken.
    initial begin
        logic          in_hold = 1'b0;
        logic [OW-1:0] held = '0;
        forever begin
            @(negedge iClk);
            if (iRst) begin
                in_hold = 1'b0; iResRdy = 1'b0;
            end else if (oResVld) begin
                if (!in_hold) begin
                    res_pulses++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 32'(oResData), 32'hFFFFFFFF);
                    end else begin
                        chk("res_data", 32'(oResData), 32'(exp_q.pop_front()));
                    end
                    held = oResData;
                    in_hold = 1'b1;
                end else begin
                    chk("res_hold", 32'(oResData), 32'(held));
                end
                iResRdy = !bp && ($urandom_range(0, 2) != 0);
                if (iResRdy) in_hold = 1'b0;
            end else begin
                in_hold = 1'b0;
                iResRdy = !bp && ($urandom_range(0, 1) == 1);
            end
        end
    end

    initial begin
        logic [SW-1:0] v;
        int acc, guard, pulses0;

        // Reset state
        repeat (3) @(negedge iClk);
        chk("rst_int_en", 32'(oIntEn), 0);
        chk("rst_res_vld", 32'(oResVld), 0);
        chk("rst_res_data", 32'(oResData), 0);
        chk("rst_int_data", 32'(oIntData), 0);
        chk("rst_cnt", 32'(oSampleCnt), 0);
        chk("rst_tmo", 32'(oTimeout), 0);
        chk("rst_busy", 32'(oBusy), 0);
        iRst = 1'b0;
        @(posedge iClk);
        #1 chk("rdy_after_rst", 32'(oStateRdy), 1);

        // Latency of the first sample
        v = 12'b011110010001;
        @(negedge iClk);
        iStateVld = 1'b1; iState = v;
        model_accept(v, 3);
        @(posedge iClk);
        #1 iStateVld = 1'b0;
        @(posedge iClk);
        #1 chk("load_en_low", 32'(oIntEn), 0);
        chk("load_data", 32'(oIntData), 32'(v));
        @(posedge iClk);
        #1 chk("run_en_high", 32'(oIntEn), 1);

        // Washout: ten samples in total, only the last two survive
        for (int i = 0; i < 9; i++) push(SW'($urandom), $urandom_range(0, 6));
        wait_idle();
        chk("washout_cnt", 32'(oSampleCnt), 10);
        chk("washout_pulses", 32'(res_pulses), 2);

        // Result on the last allowed RUN cycle is accepted
        push(SW'($urandom), TMO - 1);
        wait_idle();
        chk("last_cycle_tmo", 32'(oTimeout), 0);
        chk("last_cycle_cnt", 32'(oSampleCnt), 32'(mcnt));

        // Backpressure: with a result held, exactly two more states are accepted
        bp = 1'b1;
        push(SW'($urandom), 2);
        guard = 0;
        while (!oResVld && guard < 500) begin @(negedge iClk); guard++; end
        chk("bp_res_vld", 32'(oResVld), 1);
        acc = 0;
        guard = 0;
        @(negedge iClk);
        while (guard < 20) begin
            v = SW'($urandom);
            iStateVld = 1'b1; iState = v;
            if (!oStateRdy) break;
            model_accept(v, $urandom_range(0, 5));
            acc++;
            @(negedge iClk);
            guard++;
        end
        iStateVld = 1'b0;
        chk("bp_accepted", 32'(acc), 2);
        chk("bp_rdy_low", 32'(oStateRdy), 0);
        repeat (4) @(negedge iClk);
        chk("bp_rdy_stays_low", 32'(oStateRdy), 0);
        bp = 1'b0;
        wait_idle();
        chk("bp_cnt", 32'(oSampleCnt), 32'(mcnt));

        // Timeout: interpreter never answers, next entry still runs
        push(SW'($urandom), 1000);
        push(SW'($urandom), 2);
        wait_idle();
        chk("tmo_run_len", 32'(tmo_len), TMO);
        chk("tmo_flag", 32'(oTimeout), 32'(exp_tmo));
        chk("tmo_cnt", 32'(oSampleCnt), 32'(mcnt));
        for (int i = 0; i < 4; i++) push(SW'($urandom), $urandom_range(0, 10));
        wait_idle();
        chk("tmo_sticky", 32'(oTimeout), 1);

        // Saturation of the completed-sample counter
        @(negedge iClk);
        force dut.sample_cnt_q = 16'hFFFE;
        @(negedge iClk);
        release dut.sample_cnt_q;
        mcnt = 16'hFFFE;
        pulses0 = res_pulses;
        for (int i = 0; i < 3; i++) push(SW'($urandom), $urandom_range(0, 4));
        wait_idle();
        chk("sat_cnt", 32'(oSampleCnt), 32'hFFFF);
        chk("sat_pulses", 32'(res_pulses - pulses0), 3);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset while RUN
        push(SW'($urandom), 1000);
        push(SW'($urandom), 1000);
        guard = 0;
        while (!oIntEn && guard < 100) begin @(negedge iClk); guard++; end
        chk("pre_rst_en", 32'(oIntEn), 1);
        #2 iRst = 1'b1;
        #1;
        chk("arst_int_en", 32'(oIntEn), 0);
        chk("arst_res_vld", 32'(oResVld), 0);
        chk("arst_cnt", 32'(oSampleCnt), 0);
        chk("arst_tmo", 32'(oTimeout), 0);
        chk("arst_busy", 32'(oBusy), 0);
        exp_q.delete(); interp_v_q.delete(); interp_d_q.delete();
        mcnt = 0; exp_tmo = 1'b0;
        @(negedge iClk);
        iRst = 1'b0;
        @(posedge iClk);
        #1 chk("arst_rdy", 32'(oStateRdy), 1);
        repeat (5) @(negedge iClk);
        chk("arst_fifo_empty_en", 32'(oIntEn), 0);
        chk("arst_fifo_empty_busy", 32'(oBusy), 0);
        push(SW'($urandom), 1);
        wait_idle();
        chk("post_rst_cnt", 32'(oSampleCnt), 1);
        chk("post_rst_pending", 32'(interp_v_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
